// File: rtl/far_mem_ctrl_if.sv
// Far-memory request/response bus between the cache far-memory port and far_mem_ctrl.
// svc_stall is a service-freeze hook held low in normal operation.
interface far_mem_ctrl_if #(
    parameter int CL_WIDTH   = 128,
    parameter int ADRS_WIDTH = 12
);
    logic                  fm_req_valid;
    logic [1:0]            fm_req_opcode;
    logic [ADRS_WIDTH-1:0] fm_req_address;
    logic [CL_WIDTH-1:0]   fm_req_data;
    logic                  fm_req_ready;
    logic                  fm_rsp_valid;
    logic [ADRS_WIDTH-1:0] fm_rsp_address;
    logic [CL_WIDTH-1:0]   fm_rsp_data;
    logic [3:0]            fill_outstanding;
    logic                  overflow_err;
    logic                  illegal_op_err;
    logic                  svc_stall;

    modport master (
        output fm_req_valid, fm_req_opcode, fm_req_address, fm_req_data, svc_stall,
        input  fm_req_ready, fm_rsp_valid, fm_rsp_address, fm_rsp_data,
               fill_outstanding, overflow_err, illegal_op_err
    );

    modport slave (
        input  fm_req_valid, fm_req_opcode, fm_req_address, fm_req_data, svc_stall,
        output fm_req_ready, fm_rsp_valid, fm_rsp_address, fm_rsp_data,
               fill_outstanding, overflow_err, illegal_op_err
    );
endinterface

// File: rtl/far_mem_ctrl.sv
// Far-memory controller: in-order request FIFO serviced one entry per cycle against a
// cache-line array, with fill responses returned through a fixed-latency pipeline.
module far_mem_ctrl #(
    parameter int         CL_WIDTH       = 128,
    parameter int         ADRS_WIDTH     = 12,
    parameter int         RD_LATENCY     = 10,
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [1:0] FILL_REQ_OP    = 2'b00,
    parameter logic [1:0] DIRTY_EVICT_OP = 2'b01
) (
    input logic           clk,
    input logic           rst,
    far_mem_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LINES = 2 ** ADRS_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]            op;
        logic [ADRS_WIDTH-1:0] addr;
        logic [CL_WIDTH-1:0]   data;
    } req_t;

    req_t                fifo_mem [FIFO_DEPTH];
    logic [CL_WIDTH-1:0] array    [LINES];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic [3:0]       fill_out_q, fill_out_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    // Stage 0 is the synchronous array read; stages 1..RD_LATENCY form the return delay.
    logic                  pipe_vld_q  [RD_LATENCY+1];
    logic [ADRS_WIDTH-1:0] pipe_addr_q [RD_LATENCY+1];
    logic [CL_WIDTH-1:0]   pipe_data_q [RD_LATENCY+1];

    req_t req_in;
    req_t head;
    logic push;
    logic pop;
    logic svc_fill;
    logic svc_evict;
    logic svc_illegal;
    logic fill_accept;
    logic rsp_fire;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it
    // unassigned; a missing default silently infers a latch.
    always_comb begin
        req_in      = '{op: bus.fm_req_opcode, addr: bus.fm_req_address, data: bus.fm_req_data};
        head        = fifo_mem[rd_ptr_q];
        push        = bus.fm_req_valid && ready_q;
        pop         = (count_q != '0) && !bus.svc_stall;
        svc_fill    = pop && (head.op == FILL_REQ_OP);
        svc_evict   = pop && (head.op == DIRTY_EVICT_OP);
        svc_illegal = pop && !svc_fill && !svc_evict;
        fill_accept = push && (bus.fm_req_opcode == FILL_REQ_OP);
        rsp_fire    = pipe_vld_q[RD_LATENCY];

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        ready_d = (count_d != FULL_CNT);

        fill_out_d = fill_out_q;
        if (fill_accept && !rsp_fire && (fill_out_q != 4'hF)) begin
            fill_out_d = fill_out_q + 4'd1;
        end else if (rsp_fire && !fill_accept && (fill_out_q != 4'h0)) begin
            fill_out_d = fill_out_q - 4'd1;
        end

        overflow_d = overflow_q || (bus.fm_req_valid && !ready_q);
        illegal_d  = illegal_q || svc_illegal;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            fill_out_q <= 4'h0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            fill_out_q <= fill_out_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    // NOTE: storage arrays carry no reset; validity comes from the reset pointers and
    // count, and leaving reset off lets them map onto RAM macros.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= req_in;
        end
    end

    always_ff @(posedge clk) begin
        if (svc_evict) begin
            array[head.addr] <= head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= svc_fill;
            if (svc_fill) begin
                pipe_addr_q[0] <= head.addr;
                pipe_data_q[0] <= array[head.addr];
            end
            for (int i = 1; i <= RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    assign bus.fm_req_ready     = ready_q;
    assign bus.fm_rsp_valid     = pipe_vld_q[RD_LATENCY];
    assign bus.fm_rsp_address   = pipe_addr_q[RD_LATENCY];
    assign bus.fm_rsp_data      = pipe_data_q[RD_LATENCY];
    assign bus.fill_outstanding = fill_out_q;
    assign bus.overflow_err     = overflow_q;
    assign bus.illegal_op_err   = illegal_q;
endmodule

// File: tb/tb_far_mem_ctrl.sv
// Scoreboard bench for far_mem_ctrl: a default build plus a FIFO_DEPTH=2 build used
// with the service-stall hook to exercise overflow.
module tb_far_mem_ctrl;
    localparam logic [1:0] FILL  = 2'b00;
    localparam logic [1:0] EVICT = 2'b01;
    localparam logic [1:0] BADOP = 2'b11;
    localparam int         LAT   = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    far_mem_ctrl_if #(.CL_WIDTH(128), .ADRS_WIDTH(12)) ifc ();
    far_mem_ctrl_if #(.CL_WIDTH(128), .ADRS_WIDTH(12)) ifs ();

    far_mem_ctrl #(.FIFO_DEPTH(8)) dut   (.clk(clk), .rst(rst), .bus(ifc.slave));
    far_mem_ctrl #(.FIFO_DEPTH(2)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

    typedef struct {
        logic [11:0]  addr;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t sb_q  [$];
    exp_t sbs_q [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   peak   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (!rst && ifc.fm_rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got addr %h expected no response", ifc.fm_rsp_address);
            end else begin
                e = sb_q.pop_front();
                check("rsp_addr", ifc.fm_rsp_address, e.addr);
                check("rsp_data", ifc.fm_rsp_data, e.data);
                check("rsp_cycle", cyc, e.cyc);
            end
        end
        if (int'(ifc.fill_outstanding) > peak) peak = int'(ifc.fill_outstanding);
    end

    always @(negedge clk) begin : mon_small
        exp_t e;
        if (!rst && ifs.fm_rsp_valid) begin
            if (sbs_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp_small: got addr %h expected no response", ifs.fm_rsp_address);
            end else begin
                e = sbs_q.pop_front();
                check("rsp_addr_small", ifs.fm_rsp_address, e.addr);
                check("rsp_data_small", ifs.fm_rsp_data, e.data);
            end
        end
    end

    // Called right after a posedge (+#1); leaves the bench in the same phase.
    task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [127:0] data,
                        input bit expect_rsp, input logic [127:0] rsp_data);
        ifc.fm_req_valid   = 1'b1;
        ifc.fm_req_opcode  = op;
        ifc.fm_req_address = addr;
        ifc.fm_req_data    = data;
        @(posedge clk);
        #1;
        if (expect_rsp) sb_q.push_back('{addr, rsp_data, cyc + LAT});
        ifc.fm_req_valid = 1'b0;
    endtask

    task automatic send_s(input logic [1:0] op, input logic [11:0] addr, input logic [127:0] data);
        ifs.fm_req_valid   = 1'b1;
        ifs.fm_req_opcode  = op;
        ifs.fm_req_address = addr;
        ifs.fm_req_data    = data;
        @(posedge clk);
        #1;
        ifs.fm_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (sb_q.size() != 0 || sbs_q.size() != 0); i++) @(negedge clk);
        if (sb_q.size() != 0 || sbs_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d responses pending expected 0", name, sb_q.size() + sbs_q.size());
            sb_q.delete();
            sbs_q.delete();
        end
        idle(3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},    ifc.fm_req_ready, 1'b1);
        check({tag, "_rsp_vld"},  ifc.fm_rsp_valid, 1'b0);
        check({tag, "_rsp_addr"}, ifc.fm_rsp_address, 12'h000);
        check({tag, "_rsp_data"}, ifc.fm_rsp_data, 128'h0);
        check({tag, "_fill_out"}, ifc.fill_outstanding, 4'd0);
        check({tag, "_ovf"},      ifc.overflow_err, 1'b0);
        check({tag, "_ill"},      ifc.illegal_op_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.fm_req_valid = 1'b0; ifc.fm_req_opcode = FILL; ifc.fm_req_address = '0;
        ifc.fm_req_data  = '0;   ifc.svc_stall     = 1'b0;
        ifs.fm_req_valid = 1'b0; ifs.fm_req_opcode = FILL; ifs.fm_req_address = '0;
        ifs.fm_req_data  = '0;   ifs.svc_stall     = 1'b0;

        dut.array[12'h010] = {16{8'hA5}};
        dut.array[12'h021] = 128'hC0DE_0021_C0DE_0021_C0DE_0021_C0DE_0021;
        dut.array[12'h030] = 128'h3030_3030;
        for (int i = 0; i < 4; i++) dut.array[i] = 128'h1000 + 128'(i);
        dut_s.array[12'h003] = 128'h5555;

        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        idle(1);

        // Single fill: 11-edge latency, outstanding 1 -> 0.
        send(FILL, 12'h010, '0, 1'b1, {16{8'hA5}});
        check("fill_out_single_1", ifc.fill_outstanding, 4'd1);
        drain("single");
        check("fill_out_single_0", ifc.fill_outstanding, 4'd0);

        // RAW ordering and untouched line.
        send(EVICT, 12'h020, 128'h1234, 1'b0, '0);
        send(FILL,  12'h020, '0, 1'b1, 128'h1234);
        send(FILL,  12'h021, '0, 1'b1, 128'hC0DE_0021_C0DE_0021_C0DE_0021_C0DE_0021);
        drain("raw");

        // Back-to-back fills return on consecutive cycles.
        peak = 0;
        for (int i = 0; i < 4; i++) send(FILL, 12'(i), '0, 1'b1, 128'h1000 + 128'(i));
        drain("b2b");
        check("fill_out_peak", peak, 4);
        check("fill_out_b2b_0", ifc.fill_outstanding, 4'd0);

        // Continuous evicts never fill the FIFO; last write is readable.
        for (int i = 0; i < 9; i++) begin
            send(EVICT, 12'h100 + 12'(i), 128'hE0 + 128'(i), 1'b0, '0);
            check("ready_hold", ifc.fm_req_ready, 1'b1);
        end
        send(FILL, 12'h108, '0, 1'b1, 128'hE8);
        drain("evict_stream");
        check("ovf_clear", ifc.overflow_err, 1'b0);

        // Illegal opcode: no write, no response, sticky flag.
        check("ill_before", ifc.illegal_op_err, 1'b0);
        send(BADOP, 12'h030, 128'hBAD, 1'b0, '0);
        idle(2);
        check("ill_set", ifc.illegal_op_err, 1'b1);
        send(FILL, 12'h030, '0, 1'b1, 128'h3030_3030);
        drain("illegal");
        check("ill_sticky", ifc.illegal_op_err, 1'b1);

        // Reset mid-flight: in-flight fills vanish, array retained.
        for (int i = 0; i < 3; i++) send(FILL, 12'(i), '0, 1'b0, '0);
        check("fill_out_3", ifc.fill_outstanding, 4'd3);
        idle(5);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        idle(20);
        send(FILL, 12'h003, '0, 1'b1, 128'h1003);
        send(FILL, 12'h020, '0, 1'b1, 128'h1234);
        drain("post_reset");
        check("fill_out_post_0", ifc.fill_outstanding, 4'd0);

        // Depth-2 build with service frozen: third request is dropped.
        ifs.svc_stall = 1'b1;
        send_s(EVICT, 12'h001, 128'h11);
        check("small_ready_1", ifs.fm_req_ready, 1'b1);
        send_s(EVICT, 12'h002, 128'h22);
        check("small_ready_full", ifs.fm_req_ready, 1'b0);
        check("small_ovf_before", ifs.overflow_err, 1'b0);
        send_s(EVICT, 12'h003, 128'h33);
        check("small_ovf_set", ifs.overflow_err, 1'b1);
        ifs.svc_stall = 1'b0;
        idle(5);
        check("small_ovf_sticky", ifs.overflow_err, 1'b1);
        check("small_ready_back", ifs.fm_req_ready, 1'b1);
        send_s(FILL, 12'h003, '0);
        sbs_q.push_back('{12'h003, 128'h5555, 0});
        send_s(FILL, 12'h002, '0);
        sbs_q.push_back('{12'h002, 128'h22, 0});
        drain("small");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
